// File: rtl/sense_hold_timer_if.sv
// Sense/hold timer bus: per-channel sense inputs and the hold status outputs.
// Signalling is level/pulse based with no handshake: sense is a raw level the
// timer samples every clock; busy/remaining are levels, done/tick are one-clk
// pulses. state_dbg mirrors each channel FSM (1 = HOLD) for checkers.
interface sense_hold_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
);
  logic [NUM_CH-1:0]       sense;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH*CNT_W-1:0] remaining;
  logic                    tick;
  logic [NUM_CH-1:0]       state_dbg;

  modport master (
    output sense,
    input  busy, done, remaining, tick, state_dbg
  );

  modport slave (
    input  sense,
    output busy, done, remaining, tick, state_dbg
  );
endinterface

// File: rtl/sense_hold_timer.sv
// Multi-channel sense/hold timer. A shared prescaler produces a tick every
// DIV clocks; each channel synchronizes its sense input, detects a rising
// edge and then holds busy for HOLD_TICKS ticks, pulsing done on expiry.
// Optional feature: define HOLD_RETRIGGER_EN to let a new rise during a hold
// reload the tick counter instead of being ignored.
module sense_hold_timer #(
  parameter int NUM_CH     = 4,
  parameter int DIV        = 50000000,
  parameter int HOLD_TICKS = 5,
  parameter int CNT_W      = 4
) (
  input logic              clk,
  input logic              Reset,
  sense_hold_timer_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef HOLD_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic [NUM_CH-1:0] sync1, sync2, hist, rise;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  rem_q   [NUM_CH];
  logic [CNT_W-1:0]  rem_d   [NUM_CH];
  logic [NUM_CH-1:0] done_q, done_d;

  // Free-running prescaler, wraps after DIV-1.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Tick is forced low in reset so DIV=1 still shows tick=0 while held.
  assign tick = (pre_cnt == PRE_LAST) && !Reset;

  // Two-stage synchronizer plus history stage for rise detection.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= bus.sense;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

  // Per-channel FSM, counter and done registers.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        rem_q[i]   <= '0;
      end
      done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      done_q <= done_d;
    end
  end

  // Next-state: load on rise, count down on tick, expire at the last tick.
  always_comb begin
    done_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      case (state_q[i])
        S_IDLE: begin
          // A coincident tick is deliberately not applied on the load cycle.
          if (rise[i]) begin
            state_d[i] = S_HOLD;
            rem_d[i]   = HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (RETRIGGER && rise[i]) begin
            // Reload wins over a coincident final tick: no expiry, no done.
            rem_d[i] = HOLD_LOAD;
          end else if (tick) begin
            // <= 1 also catches a corrupted zero so the count never wraps.
            if (rem_q[i] <= CNT_ONE) begin
              state_d[i] = S_IDLE;
              rem_d[i]   = '0;
              done_d[i]  = 1'b1;
            end else begin
              rem_d[i] = rem_q[i] - CNT_ONE;
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          rem_d[i]   = '0;
        end
      endcase
    end
  end

  // Output mapping from the registered channel state.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.busy[g]                      = (state_q[g] == S_HOLD);
    assign bus.state_dbg[g]                 = state_q[g];
    assign bus.remaining[g*CNT_W +: CNT_W]  = rem_q[g];
  end

  assign bus.done = done_q;
  assign bus.tick = tick;

endmodule

// File: doc/sense_hold_timer.md
SENSE_HOLD_TIMER -- requirements
Module: sense_hold_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent sense/hold channels, range 1..16.
REQ-002 Parameter DIV, default 50000000: clk cycles per tick, range >=1 (50 MHz -> 1 Hz).
REQ-003 Parameter HOLD_TICKS, default 5: hold length in ticks, range 1..2^CNT_W-1.
REQ-004 Parameter CNT_W, default 4: width of each per-channel tick counter.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 sense  input  NUM_CH  asynchronous per-channel trigger (ball sensor), level signal.
REQ-008 busy  output  NUM_CH  high while the channel is holding.
REQ-009 done  output  NUM_CH  one-clk pulse when a hold expires.
REQ-010 remaining  output  NUM_CH*CNT_W  per-channel ticks left; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-011 tick  output  1  one-clk pulse from the shared prescaler.

Function
REQ-012 Prescaler: free-running counter 0..DIV-1, wraps to 0; tick=1 exactly in the cycle the count equals DIV-1; DIV=1 gives tick=1 every cycle.
REQ-013 Each sense bit passes a 2-FF synchronizer plus one history FF; rise[i] = sync2 & ~hist.
REQ-014 Latency: sense first sampled high at clk edge k -> busy high after edge k+2.
REQ-015 Per-channel FSM, two states: IDLE (busy=0, remaining=0) and HOLD (busy=1).
REQ-016 IDLE + rise -> HOLD; remaining loads HOLD_TICKS; a coincident tick does not decrement on that cycle.
REQ-017 HOLD + tick + remaining>1 -> remaining decrements by 1 and the channel stays in HOLD.
REQ-018 HOLD + tick + remaining==1 -> IDLE; remaining=0; done=1 for exactly the next clk cycle, on the same edge that busy falls.
REQ-019 HOLD without tick: remaining holds its value.
REQ-020 Sense held high produces one rise only; re-arming requires sense to return low.
REQ-021 Channels are fully independent; any number of channels may start or expire in the same cycle.
REQ-022 Hold duration is (HOLD_TICKS-1)*DIV+1 .. HOLD_TICKS*DIV clk cycles, depending on tick phase at trigger.
REQ-023 remaining never underflows and never exceeds HOLD_TICKS.

Reset
REQ-024 Reset asserted: prescaler=0, tick=0, all synchronizer/history FFs=0, all FSMs in IDLE, busy=0, done=0, remaining=0, all immediately and asynchronously.
REQ-025 Reset mid-hold aborts the hold with no done pulse.
REQ-026 After Reset deasserts, a sense already high produces a rise.

Configuration
REQ-027 Macro HOLD_RETRIGGER_EN defined: rise in HOLD reloads remaining to HOLD_TICKS and the channel stays in HOLD. Rise coincident with the final tick reloads, stays in HOLD, and issues no done.
REQ-028 HOLD_RETRIGGER_EN undefined: rise in HOLD is ignored. Rise coincident with the final tick is also ignored; the channel goes to IDLE and done pulses normally.

Verification (NUM_CH=2, DIV=4, HOLD_TICKS=3, CNT_W=4)
REQ-029 Reset mid-count -> tick, busy, done, remaining all 0 the same cycle; prescaler restarts so the first tick lands 4 cycles after deassert.
REQ-030 Single sense0 pulse (2 clk wide) -> busy0 rises 2 edges after first sample; remaining0 goes 3,2,1 on successive ticks; busy0 falls and done0 pulses 1 cycle after the 3rd tick; channel 1 is untouched.
REQ-031 sense0 held high for 40 cycles -> exactly one hold and one done0 pulse.
REQ-032 Second sense0 rise while remaining0=1 -> with HOLD_RETRIGGER_EN: remaining0 reloads to 3, no done0 at the original expiry; without: ignored, done0 at the original expiry.
REQ-033 sense0 and sense1 rise in the same cycle -> busy and done match cycle-for-cycle on both channels.
REQ-034 Rise coincident with tick in IDLE -> remaining=3 after that cycle, not 2.
